// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state REQ/WAIT/HOLD engine with at most one outstanding memory
// request. Redirects from the branch unit override everything; stale in-flight responses are dropped.
module fetch_unit #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    input  logic                  if_ready_i
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] req_pc_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] if_pc_q;
    logic                  discard_q;

    logic [DATA_WIDTH-1:0] pc_inc_d;
    logic [DATA_WIDTH-1:0] redirect_tgt_d;

    assign pc_inc_d       = pc_q + DATA_WIDTH'(4);
    assign redirect_tgt_d = redirect_pc_i & ~DATA_WIDTH'(3);

    // Request is gated by reset so it is low while rst_i is held and high in the first cycle after release.
    assign imem_req_o  = (state_q == S_REQ) && !rst_i;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = (state_q == S_HOLD) && !redirect_i;
    assign if_instr_o  = instr_q;
    assign if_pc_o     = if_pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            instr_q   <= '0;
            if_pc_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (redirect_i) begin
                        pc_q <= redirect_tgt_d;
                        if (imem_gnt_i) begin
                            // The granted fetch is on the old path; its response must be thrown away.
                            state_q   <= S_WAIT;
                            discard_q <= 1'b1;
                        end
                    end else if (imem_gnt_i) begin
                        state_q  <= S_WAIT;
                        req_pc_q <= pc_q;
                        pc_q     <= pc_inc_d;
                    end
                end
                S_WAIT: begin
                    if (redirect_i) begin
                        pc_q <= redirect_tgt_d;
                        if (imem_rvalid_i) begin
                            state_q   <= S_REQ;
                            discard_q <= 1'b0;
                        end else begin
                            discard_q <= 1'b1;
                        end
                    end else if (imem_rvalid_i) begin
                        if (discard_q) begin
                            state_q   <= S_REQ;
                            discard_q <= 1'b0;
                        end else begin
                            state_q <= S_HOLD;
                            instr_q <= imem_rdata_i;
                            if_pc_q <= req_pc_q;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_tgt_d;
                        state_q <= S_REQ;
                    end else if (if_ready_i) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: the bench plays the instruction memory and decode stage
// cycle by cycle and compares DUT outputs against hand-derived values.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_ready_i;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_ready_i    (if_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then let combinational outputs settle.
    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk_i);
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rdata;
        if_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
    endtask

    initial begin
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if_ready_i    = 1'b0;

        repeat (2) @(negedge clk_i);
        #1;
        chk_val("rst_req",   {31'b0, imem_req_o}, 32'd0);
        chk_val("rst_valid", {31'b0, if_valid_o}, 32'd0);
        chk_val("rst_instr", if_instr_o, 32'd0);
        chk_val("rst_pc",    if_pc_o, 32'd0);

        // Basic fetch: grant immediately, respond next cycle, decode ready.
        @(negedge clk_i);
        rst_i      = 1'b0;
        imem_gnt_i = 1'b1;
        #1;
        chk_val("first_req",  {31'b0, imem_req_o}, 32'd1);
        chk_val("first_addr", imem_addr_o, 32'h0);
        drive(0, 1, 32'h0000_0013, 0, 0, 0);
        chk_val("wait_req", {31'b0, imem_req_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        chk_val("b_valid", {31'b0, if_valid_o}, 32'd1);
        chk_val("b_instr", if_instr_o, 32'h0000_0013);
        chk_val("b_pc",    if_pc_o, 32'h0);
        drive(1, 0, 0, 0, 0, 0);
        chk_val("b_next_req",  {31'b0, imem_req_o}, 32'd1);
        chk_val("b_next_addr", imem_addr_o, 32'h4);

        // Backpressure: decode stalls for 5 cycles in HOLD.
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk_val("stall_valid", {31'b0, if_valid_o}, 32'd1);
            chk_val("stall_instr", if_instr_o, 32'hDEAD_BEEF);
            chk_val("stall_pc",    if_pc_o, 32'h4);
            chk_val("stall_req",   {31'b0, imem_req_o}, 32'd0);
        end
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_val("stall_next_addr", imem_addr_o, 32'h8);

        // Redirect while waiting: the late response is dropped.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h100);
        chk_val("rw_valid", {31'b0, if_valid_o}, 32'd0);
        drive(0, 1, 32'h0BAD_0001, 1, 0, 0);
        chk_val("rw_drop_valid", {31'b0, if_valid_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        chk_val("rw_req",   {31'b0, imem_req_o}, 32'd1);
        chk_val("rw_addr",  imem_addr_o, 32'h100);
        chk_val("rw_valid2", {31'b0, if_valid_o}, 32'd0);

        // Redirect with grant in the same cycle: target wins over pc+4, response discarded.
        drive(1, 0, 0, 1, 1, 32'h100);
        drive(0, 1, 32'h0BAD_0002, 1, 0, 0);
        chk_val("rg_valid", {31'b0, if_valid_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        chk_val("rg_req",    {31'b0, imem_req_o}, 32'd1);
        chk_val("rg_addr",   imem_addr_o, 32'h100);
        chk_val("rg_valid2", {31'b0, if_valid_o}, 32'd0);

        // Redirect in HOLD with ready high: no transfer, refetch from target.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h1111_1111, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 32'h100);
        chk_val("rh_valid", {31'b0, if_valid_o}, 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        chk_val("rh_req",  {31'b0, imem_req_o}, 32'd1);
        chk_val("rh_addr", imem_addr_o, 32'h100);
        drive(0, 1, 32'h2222_2222, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk_val("rh_valid2", {31'b0, if_valid_o}, 32'd1);
        chk_val("rh_pc",     if_pc_o, 32'h100);
        chk_val("rh_instr",  if_instr_o, 32'h2222_2222);

        // Misaligned redirect target is forced to word alignment.
        drive(0, 0, 0, 0, 1, 32'h103);
        chk_val("ma_req", {31'b0, imem_req_o}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        chk_val("ma_addr", imem_addr_o, 32'h100);

        // Redirect in WAIT coinciding with a response: drop it and go straight back to requesting.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h0BAD_0003, 1, 1, 32'h40);
        chk_val("rwv_valid", {31'b0, if_valid_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        chk_val("rwv_req",   {31'b0, imem_req_o}, 32'd1);
        chk_val("rwv_addr",  imem_addr_o, 32'h40);
        chk_val("rwv_valid2", {31'b0, if_valid_o}, 32'd0);

        // PC increment wraps at the top of the address space.
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0, 0);
        chk_val("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
        drive(0, 1, 32'h3333_3333, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk_val("wr_valid", {31'b0, if_valid_o}, 32'd1);
        chk_val("wr_pc",    if_pc_o, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0);
        chk_val("wr_next_req",  {31'b0, imem_req_o}, 32'd1);
        chk_val("wr_next_addr", imem_addr_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; SHALL be word-aligned.
REQ-002 Parameter DATA_WIDTH, default pkg_config DATA_WIDTH (32), width of PC, address and instruction.
REQ-003 clk_i  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 redirect_i  input  1  branch-unit take (taken branch, JAL or JALR); fetch from redirect_pc_i.
REQ-006 redirect_pc_i  input  DATA_WIDTH  redirect target address.
REQ-007 imem_req_o  output  1  instruction memory request.
REQ-008 imem_addr_o  output  DATA_WIDTH  request address.
REQ-009 imem_gnt_i  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid_i  input  1  read data valid; at most one response per granted request, earliest one cycle after grant.
REQ-011 imem_rdata_i  input  DATA_WIDTH  instruction word.
REQ-012 if_valid_o  output  1  instruction available to decode.
REQ-013 if_instr_o  output  DATA_WIDTH  fetched instruction.
REQ-014 if_pc_o  output  DATA_WIDTH  address of if_instr_o.
REQ-015 if_ready_i  input  1  decode accepts; transfer occurs when if_valid_o and if_ready_i are both 1 at a rising edge.

Function
REQ-016 Three-state FSM: REQ, WAIT, HOLD; one outstanding memory request at most.
REQ-017 REQ: imem_req_o=1, imem_addr_o=pc_q; on imem_gnt_i -> WAIT, req_pc_q<=pc_q, pc_q<=pc_q+4; else stay.
REQ-018 WAIT: imem_req_o=0; on imem_rvalid_i with discard_q=0 -> HOLD, capture imem_rdata_i into if_instr_o and req_pc_q into if_pc_o.
REQ-019 WAIT with discard_q=1: on imem_rvalid_i drop data, clear discard_q, -> REQ.
REQ-020 HOLD: if_valid_o=1, imem_req_o=0; on transfer -> REQ; if_instr_o/if_pc_o SHALL remain stable until transfer.
REQ-021 if_valid_o SHALL equal (state==HOLD) and not redirect_i, combinationally.
REQ-022 redirect_i SHALL take priority over all other events: pc_q<=redirect_pc_i with bits [1:0] forced to 0.
REQ-023 Redirect in REQ without grant: stay REQ; next-cycle imem_addr_o is new target.
REQ-024 Redirect in REQ with grant same cycle: -> WAIT with discard_q=1; pc_q takes redirect target, not +4.
REQ-025 Redirect in WAIT: discard_q<=1 unless imem_rvalid_i same cycle, then drop response and -> REQ.
REQ-026 Redirect in HOLD: no transfer regardless of if_ready_i; held instruction dropped; -> REQ.
REQ-027 pc_q+4 SHALL wrap modulo 2^DATA_WIDTH.
REQ-028 Minimum throughput: one instruction per 3 cycles with single-cycle grant and response.

Reset
REQ-029 While rst_i=1: state=REQ, pc_q=RESET_PC, discard_q=0, imem_req_o=0, if_valid_o=0, if_instr_o=0, if_pc_o=0, req_pc_q=0.
REQ-030 imem_req_o SHALL assert in the first cycle after rst_i deasserts, address RESET_PC.
REQ-031 Reset mid-WAIT: a response arriving after reset release for the pre-reset request is not expected; memory is reset together.

Verification
REQ-032 Reset release, gnt immediate, rvalid next cycle with 0x00000013, ready=1 -> if_valid_o with if_pc_o=0x0, then request at 0x4.
REQ-033 if_ready_i held 0 for 5 cycles in HOLD -> if_valid_o stays 1, if_instr_o/if_pc_o unchanged, imem_req_o=0.
REQ-034 redirect_i=1, redirect_pc_i=0x100 while in WAIT -> returned data dropped, next request address 0x100.
REQ-035 redirect_i with imem_gnt_i same cycle in REQ -> response discarded, next request 0x100, no instruction to decode from old path.
REQ-036 redirect in HOLD with if_ready_i=1 -> if_valid_o=0 that cycle, next delivered if_pc_o=0x100.
REQ-037 redirect_pc_i=0x103 -> request address 0x100; pc_q=0xFFFFFFFC fetch -> next address 0x0.
